// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the DS1302-style RTC read and write engines.
// Read FSM state encoding, register command bytes and read-sequence helpers.
// RTC_READ_HOURS_EN extends the read sequence with the hours transaction.
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } rd_state_e;

   // Read commands (bit 0 set selects read)
   localparam logic [7:0] ADR_RD_SEC  = 8'h81;
   localparam logic [7:0] ADR_RD_MIN  = 8'h83;
   localparam logic [7:0] ADR_RD_HR   = 8'h85;

   // Write commands used by the writer on the same pins
   localparam logic [7:0] ADR_WR_SEC  = 8'h80;
   localparam logic [7:0] ADR_WR_MIN  = 8'h82;
   localparam logic [7:0] ADR_WR_HR   = 8'h84;
   localparam logic [7:0] ADR_WR_CTRL = 8'h8E;

   // Index of the final transaction in one read frame
`ifdef RTC_READ_HOURS_EN
   localparam logic [1:0] RD_LAST_IDX = 2'd2;
`else
   localparam logic [1:0] RD_LAST_IDX = 2'd1;
`endif

   // Command byte for transaction index: seconds, minutes, hours
   function automatic logic [7:0] rd_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    rd_cmd = ADR_RD_SEC;
         2'd1:    rd_cmd = ADR_RD_MIN;
         default: rd_cmd = ADR_RD_HR;
      endcase
   endfunction

endpackage

// File: rtl/rtc_sclk_gen.sv
// rtc_sclk_gen: serial clock and bit-period sequencing for one RTC transaction.
// Latency: sclk starts low for SCLK_HALF clks the cycle after en_i rises; 16 periods of 2*SCLK_HALF clks.
// Backpressure: none; held cleared (sclk low, counters zero) whenever en_i is low.
module rtc_sclk_gen #(
   parameter int unsigned SCLK_HALF = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   output logic       sclk_o,
   output logic       rise_next_o,
   output logic       fall_o,
   output logic       last_period_o,
   output logic [3:0] period_o
);

   localparam int unsigned HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [HW-1:0] half_q;
   logic          sclk_q;
   logic [3:0]    period_q;
   logic          half_end;

   assign half_end = (half_q == HW'(SCLK_HALF - 1));

   // Half-period counter toggles sclk; each falling edge closes a bit period
   always_ff @(posedge clk) begin
      if (rst || !en_i) begin
         half_q   <= '0;
         sclk_q   <= 1'b0;
         period_q <= 4'd0;
      end else if (half_end) begin
         half_q <= '0;
         sclk_q <= ~sclk_q;
         if (sclk_q) begin
            period_q <= period_q + 4'd1;
         end
      end else begin
         half_q <= half_q + 1'b1;
      end
   end

   assign sclk_o        = sclk_q;
   assign rise_next_o   = en_i & ~sclk_q & half_end;
   assign fall_o        = en_i &  sclk_q & half_end;
   assign last_period_o = (period_q == 4'd15);
   assign period_o      = period_q;

endmodule

// File: rtl/rtc_read.sv
// rtc_read: DS1302-style three-wire time read controller (optional hours via RTC_READ_HOURS_EN).
// Latency: valid at N+1+T*32*SCLK_HALF+(T-1)*GAP_CYCLES after read is seen in IDLE at cycle N.
// Backpressure: read is sampled only in IDLE; requests while busy are dropped, never queued.
module rtc_read import rtc_pkg::*; #(
   parameter int unsigned SCLK_HALF  = 2,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       read,
   input  logic       io_in,
   output logic       ce,
   output logic       sclk,
   output logic       io_out,
   output logic       io_oe,
   output logic       busy,
   output logic       valid,
   output logic [3:0] data_sec_0,
   output logic [3:0] data_sec_1,
   output logic       ch,
   output logic [3:0] data_min_0,
   output logic [3:0] data_min_1
`ifdef RTC_READ_HOURS_EN
   ,
   output logic [3:0] data_hr_0,
   output logic [1:0] data_hr_1,
   output logic       mode_12h
`endif
);

   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   rd_state_e     state_q;
   logic [1:0]    idx_q;
   logic [GW-1:0] gap_q;
   logic [7:0]    tx_q;
   logic [7:0]    rx_q;
   logic          ce_q;
   logic          io_out_q;
   logic          io_oe_q;
   logic          busy_q;
   logic          valid_q;

   // Shadows collect bytes during the frame; *_o_q are the visible time outputs
   logic [7:0]    sec_sh_q, sec_d;
   logic [7:0]    min_sh_q, min_d;
   logic [7:0]    sec_o_q;
   logic [6:0]    min_o_q;
`ifdef RTC_READ_HOURS_EN
   logic [7:0]    hr_sh_q, hr_d;
   logic [6:0]    hr_o_q;
   logic          unused_hr_bit6;
`endif
   logic          unused_min_bit7;

   logic [7:0]    next_cmd;
   logic          rise_next;
   logic          fall;
   logic          last_period;
   logic [3:0]    period;

   rtc_sclk_gen #(
      .SCLK_HALF(SCLK_HALF)
   ) u_sclk_gen (
      .clk          (clk),
      .rst          (rst),
      .en_i         (ce_q),
      .sclk_o       (sclk),
      .rise_next_o  (rise_next),
      .fall_o       (fall),
      .last_period_o(last_period),
      .period_o     (period)
   );

   assign next_cmd = rd_cmd(idx_q + 2'd1);

   // Shadow view with the byte just received merged in, so the final byte
   // and the earlier ones reach the outputs on the same edge
   always_comb begin
      sec_d = sec_sh_q;
      min_d = min_sh_q;
`ifdef RTC_READ_HOURS_EN
      hr_d  = hr_sh_q;
`endif
      case (idx_q)
         2'd0:    sec_d = rx_q;
         2'd1:    min_d = rx_q;
`ifdef RTC_READ_HOURS_EN
         default: hr_d  = rx_q;
`else
         default: ;
`endif
      endcase
   end

   assign unused_min_bit7 = min_d[7];
`ifdef RTC_READ_HOURS_EN
   assign unused_hr_bit6  = hr_d[6];
`endif

   // Frame sequencer: IDLE -> (XFER -> GAP)* -> XFER -> DONE, all pin/status outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         gap_q    <= '0;
         tx_q     <= 8'd0;
         rx_q     <= 8'd0;
         ce_q     <= 1'b0;
         io_out_q <= 1'b0;
         io_oe_q  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         sec_sh_q <= 8'd0;
         min_sh_q <= 8'd0;
         sec_o_q  <= 8'd0;
         min_o_q  <= 7'd0;
`ifdef RTC_READ_HOURS_EN
         hr_sh_q  <= 8'd0;
         hr_o_q   <= 7'd0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (read) begin
                  state_q  <= XFER;
                  idx_q    <= 2'd0;
                  tx_q     <= ADR_RD_SEC;
                  io_out_q <= ADR_RD_SEC[0];
                  io_oe_q  <= 1'b1;
                  ce_q     <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            XFER: begin
               // Device data is stable by the end of the low phase
               if (rise_next && period[3]) begin
                  rx_q <= {io_in, rx_q[7:1]};
               end
               if (fall) begin
                  if (last_period) begin
                     ce_q     <= 1'b0;
                     io_out_q <= 1'b0;
                     io_oe_q  <= 1'b0;
                     sec_sh_q <= sec_d;
                     min_sh_q <= min_d;
`ifdef RTC_READ_HOURS_EN
                     hr_sh_q  <= hr_d;
`endif
                     if (idx_q == RD_LAST_IDX) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        sec_o_q <= sec_d;
                        min_o_q <= min_d[6:0];
`ifdef RTC_READ_HOURS_EN
                        hr_o_q  <= {hr_d[7], hr_d[5:0]};
`endif
                     end else begin
                        state_q <= GAP;
                        gap_q   <= '0;
                     end
                  end else if (period == 4'd7) begin
                     // Command sent: release the pin for the data byte
                     io_out_q <= 1'b0;
                     io_oe_q  <= 1'b0;
                  end else if (!period[3]) begin
                     tx_q     <= {1'b0, tx_q[7:1]};
                     io_out_q <= tx_q[1];
                  end
               end
            end
            GAP: begin
               if (gap_q == GW'(GAP_CYCLES - 1)) begin
                  state_q  <= XFER;
                  idx_q    <= idx_q + 2'd1;
                  tx_q     <= next_cmd;
                  io_out_q <= next_cmd[0];
                  io_oe_q  <= 1'b1;
                  ce_q     <= 1'b1;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ce         = ce_q;
   assign io_out     = io_out_q;
   assign io_oe      = io_oe_q;
   assign busy       = busy_q;
   assign valid      = valid_q;
   assign data_sec_0 = sec_o_q[3:0];
   assign data_sec_1 = {1'b0, sec_o_q[6:4]};
   assign ch         = sec_o_q[7];
   assign data_min_0 = min_o_q[3:0];
   assign data_min_1 = {1'b0, min_o_q[6:4]};
`ifdef RTC_READ_HOURS_EN
   assign data_hr_0  = hr_o_q[3:0];
   assign data_hr_1  = hr_o_q[5:4];
   assign mode_12h   = hr_o_q[6];
`endif

endmodule

// File: tb/tb_rtc_read.sv
// tb_rtc_read: randomized self-checking bench for rtc_read with a DS1302 device model.
// Timing windows and decoded time fields are derived from frame arithmetic, not the RTL.
module tb_rtc_read;
   localparam int SH  = 2;
   localparam int GAP = 8;
`ifdef RTC_READ_HOURS_EN
   localparam int T  = 3;
   localparam int OW = 24;
`else
   localparam int T  = 2;
   localparam int OW = 17;
`endif
   localparam int XL   = 32 * SH;
   localparam int VLAT = T * XL + (T - 1) * GAP + 1;
   localparam int LOGN = 512;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       read  = 1'b0;
   logic       io_in = 1'b0;
   logic       ce, sclk, io_out, io_oe, busy, valid, ch;
   logic [3:0] data_sec_0, data_sec_1, data_min_0, data_min_1;
`ifdef RTC_READ_HOURS_EN
   logic [3:0] data_hr_0;
   logic [1:0] data_hr_1;
   logic       mode_12h;
`endif

   int errors = 0;
   int checks = 0;

   rtc_read #(.SCLK_HALF(SH), .GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .read      (read),
      .io_in     (io_in),
      .ce        (ce),
      .sclk      (sclk),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .busy      (busy),
      .valid     (valid),
      .data_sec_0(data_sec_0),
      .data_sec_1(data_sec_1),
      .ch        (ch),
      .data_min_0(data_min_0),
      .data_min_1(data_min_1)
`ifdef RTC_READ_HOURS_EN
      ,
      .data_hr_0 (data_hr_0),
      .data_hr_1 (data_hr_1),
      .mode_12h  (mode_12h)
`endif
   );

   always #5 clk = ~clk;

   logic [OW-1:0] outs;
`ifdef RTC_READ_HOURS_EN
   assign outs = {ch, data_sec_1, data_sec_0, data_min_1, data_min_0, data_hr_1, data_hr_0, mode_12h};
`else
   assign outs = {ch, data_sec_1, data_sec_0, data_min_1, data_min_0};
`endif

   // ---------------- DS1302 device model ----------------
   logic [7:0]  dev_sec = 8'h00, dev_min = 8'h00, dev_hr = 8'h00;
   logic [7:0]  dev_cmd = 8'h00, dev_out = 8'h00;
   logic [15:0] dev_oe  = 16'h0000;
   int          rise_cnt = 0;
   logic [23:0] xq[$];   // per transaction: {io_oe at the 16 rises, command byte}

   // Command and pin direction are observed on rising sclk edges
   always @(posedge sclk or negedge ce) begin
      if (!ce) begin
         rise_cnt = 0;
      end else begin
         if (rise_cnt < 8) dev_cmd = {io_out, dev_cmd[7:1]};
         if (rise_cnt < 16) dev_oe = {io_oe, dev_oe[15:1]};
         if (rise_cnt == 7) begin
            case (dev_cmd)
               8'h81:   dev_out = dev_sec;
               8'h83:   dev_out = dev_min;
               8'h85:   dev_out = dev_hr;
               default: dev_out = 8'h00;
            endcase
         end
         if (rise_cnt == 15) xq.push_back({dev_oe, dev_cmd});
         rise_cnt++;
      end
   end

   // Read data is presented LSB first on falling sclk edges
   always @(negedge sclk or negedge ce) begin
      if (!ce) io_in = 1'b0;
      else if (rise_cnt >= 8 && rise_cnt <= 15) io_in = dev_out[3'(rise_cnt - 8)];
      else io_in = 1'b0;
   end

   // ---------------- per-cycle logs ----------------
   logic          ce_l    [LOGN];
   logic          sclk_l  [LOGN];
   logic          busy_l  [LOGN];
   logic          valid_l [LOGN];
   logic [1:0]    io_l    [LOGN];
   logic [OW-1:0] out_l   [LOGN];

   // Offset 0 is cycle N (read first driven); samples taken mid-cycle
   task automatic capture(input int n, input int hold_until, input int pulse_at, input int rst_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ce_l[i]    = ce;
         sclk_l[i]  = sclk;
         busy_l[i]  = busy;
         valid_l[i] = valid;
         io_l[i]    = {io_out, io_oe};
         out_l[i]   = outs;
         read = (i <= hold_until) || (i == pulse_at);
         rst  = (i == rst_at);
      end
      read = 1'b0;
      rst  = 1'b0;
   endtask

   function automatic logic exp_ce(input int o);
      for (int t = 0; t < T; t++) begin
         int s0 = 1 + t * (XL + GAP);
         if (o >= s0 && o < s0 + XL) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic exp_sclk(input int o);
      for (int t = 0; t < T; t++) begin
         int s0 = 1 + t * (XL + GAP);
         if (o >= s0 && o < s0 + XL) return (((o - s0) / SH) % 2) == 1;
      end
      return 1'b0;
   endfunction

   function automatic logic [OW-1:0] exp_outs(input logic [7:0] s, input logic [7:0] m);
      int sv = int'(s);
      int mv = int'(m);
      logic [16:0] base = {1'(sv / 128), 4'((sv / 16) % 8), 4'(sv % 16), 4'((mv / 16) % 8), 4'(mv % 16)};
`ifdef RTC_READ_HOURS_EN
      int hv = int'(dev_hr);
      return {base, 2'((hv / 16) % 4), 4'(hv % 16), 1'(hv / 128)};
`else
      return base;
`endif
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ce, sclk, io_out, io_oe, busy, valid, outs} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got %h required 0", {ce, sclk, io_out, io_oe, busy, valid, outs});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ce, sclk, io_out, io_oe, busy, valid, outs} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h required 0", {ce, sclk, io_out, io_oe, busy, valid, outs});
      end
   endtask

   task automatic test_frame(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
      logic [7:0]    cmds [3] = '{8'h81, 8'h83, 8'h85};
      logic [OW-1:0] prev, expv;
      int first_v = -1, nv = 0, bad_ce = 0, bad_sclk = 0, bad_busy = 0, bad_hold = 0;
      xq.delete();
      dev_sec = s; dev_min = m; dev_hr = h;
      capture(VLAT + 4, 0, -1, -1);
      prev = out_l[0];
      expv = exp_outs(s, m);
      for (int o = 1; o < VLAT + 4; o++) begin
         if (valid_l[o]) begin nv++; if (first_v < 0) first_v = o; end
         if (ce_l[o] !== exp_ce(o)) bad_ce++;
         if (sclk_l[o] !== exp_sclk(o)) bad_sclk++;
         if (busy_l[o] !== (o <= VLAT)) bad_busy++;
         if (o < VLAT && out_l[o] !== prev) bad_hold++;
         if (o > VLAT && out_l[o] !== expv) bad_hold++;
      end
      checks++;
      if (first_v !== VLAT) begin
         errors++;
         $display("FAIL frame_valid_cycle: got N+%0d required N+%0d", first_v, VLAT);
      end
      checks++;
      if (nv !== 1) begin
         errors++;
         $display("FAIL frame_valid_count: got %0d required 1", nv);
      end
      checks++;
      if (bad_ce !== 0) begin
         errors++;
         $display("FAIL frame_ce_window: got %0d bad cycles required 0", bad_ce);
      end
      checks++;
      if (bad_sclk !== 0) begin
         errors++;
         $display("FAIL frame_sclk_shape: got %0d bad cycles required 0", bad_sclk);
      end
      checks++;
      if (bad_busy !== 0) begin
         errors++;
         $display("FAIL frame_busy_window: got %0d bad cycles required 0", bad_busy);
      end
      checks++;
      if (bad_hold !== 0) begin
         errors++;
         $display("FAIL frame_output_hold: got %0d bad cycles required 0", bad_hold);
      end
      checks++;
      if (out_l[VLAT] !== expv) begin
         errors++;
         $display("FAIL frame_data: sec=%h min=%h got %h required %h", s, m, out_l[VLAT], expv);
      end
      checks++;
      if (xq.size() !== T) begin
         errors++;
         $display("FAIL frame_xact_count: got %0d required %0d", xq.size(), T);
      end
      for (int t = 0; t < T && t < xq.size(); t++) begin
         checks++;
         if (xq[t][7:0] !== cmds[t]) begin
            errors++;
            $display("FAIL frame_cmd%0d: got %h required %h", t, xq[t][7:0], cmds[t]);
         end
         checks++;
         if (xq[t][23:8] !== 16'h00FF) begin
            errors++;
            $display("FAIL frame_oe%0d: got %h required 00ff", t, xq[t][23:8]);
         end
      end
   endtask

   task automatic test_ignore_read();
      logic [OW-1:0] prev, expv;
      int first_v = -1, nv = 0, bad_busy = 0, bad_hold = 0;
      dev_sec = 8'h17; dev_min = 8'h42; dev_hr = 8'h09;
      capture(VLAT + 4, 0, 20, -1);
      prev = out_l[0];
      expv = exp_outs(8'h17, 8'h42);
      for (int o = 1; o < VLAT + 4; o++) begin
         if (valid_l[o]) begin nv++; if (first_v < 0) first_v = o; end
         if (busy_l[o] !== (o <= VLAT)) bad_busy++;
         if (o < VLAT && out_l[o] !== prev) bad_hold++;
      end
      checks++;
      if (nv !== 1) begin
         errors++;
         $display("FAIL ignore_valid_count: got %0d required 1", nv);
      end
      checks++;
      if (first_v !== VLAT) begin
         errors++;
         $display("FAIL ignore_valid_cycle: got N+%0d required N+%0d", first_v, VLAT);
      end
      checks++;
      if (bad_busy !== 0) begin
         errors++;
         $display("FAIL ignore_busy: got %0d bad cycles required 0", bad_busy);
      end
      checks++;
      if (bad_hold !== 0) begin
         errors++;
         $display("FAIL ignore_hold: got %0d bad cycles required 0", bad_hold);
      end
      checks++;
      if (out_l[VLAT] !== expv) begin
         errors++;
         $display("FAIL ignore_data: got %h required %h", out_l[VLAT], expv);
      end
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] expv;
      int v0 = -1, v1 = -1, nv = 0, nlow = 0, low_at = -1;
      dev_sec = 8'h21; dev_min = 8'h58; dev_hr = 8'h11;
      capture(2 * VLAT + 6, VLAT + 1, -1, -1);
      expv = exp_outs(8'h21, 8'h58);
      for (int o = 1; o < 2 * VLAT + 6; o++) begin
         if (valid_l[o]) begin
            nv++;
            if (v0 < 0) v0 = o; else if (v1 < 0) v1 = o;
         end
         if (o <= 2 * VLAT + 1 && !busy_l[o]) begin nlow++; low_at = o; end
      end
      checks++;
      if (nv !== 2) begin
         errors++;
         $display("FAIL b2b_valid_count: got %0d required 2", nv);
      end
      checks++;
      if (v0 !== VLAT) begin
         errors++;
         $display("FAIL b2b_valid0: got N+%0d required N+%0d", v0, VLAT);
      end
      checks++;
      if (v1 !== 2 * VLAT + 1) begin
         errors++;
         $display("FAIL b2b_valid1: got N+%0d required N+%0d", v1, 2 * VLAT + 1);
      end
      checks++;
      if (nlow !== 1) begin
         errors++;
         $display("FAIL b2b_busy_low_count: got %0d required 1", nlow);
      end
      checks++;
      if (low_at !== VLAT + 1) begin
         errors++;
         $display("FAIL b2b_busy_low_at: got N+%0d required N+%0d", low_at, VLAT + 1);
      end
      checks++;
      if (out_l[2 * VLAT + 1] !== expv) begin
         errors++;
         $display("FAIL b2b_data: got %h required %h", out_l[2 * VLAT + 1], expv);
      end
   endtask

   task automatic test_reset_mid();
      int nv = 0, busy_hi = 0;
      dev_sec = 8'h44; dev_min = 8'h10; dev_hr = 8'h05;
      capture(60, 0, -1, 30);
      for (int o = 31; o < 60; o++) begin
         if (valid_l[o]) nv++;
         if (o > 31 && busy_l[o]) busy_hi++;
      end
      checks++;
      if (busy_l[30] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_busy_before: got %b required 1", busy_l[30]);
      end
      checks++;
      if ({ce_l[31], sclk_l[31], io_l[31], busy_l[31], valid_l[31], out_l[31]} !== '0) begin
         errors++;
         $display("FAIL rstmid_zero: got %h required 0", {ce_l[31], sclk_l[31], io_l[31], busy_l[31], valid_l[31], out_l[31]});
      end
      checks++;
      if (nv !== 0) begin
         errors++;
         $display("FAIL rstmid_no_valid: got %0d required 0", nv);
      end
      checks++;
      if (busy_hi !== 0) begin
         errors++;
         $display("FAIL rstmid_idle: got %0d busy cycles required 0", busy_hi);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frame(8'h59, 8'h34, 8'h12);
      test_frame(8'hA3, 8'h07, 8'h92);
      test_ignore_read();
      test_back_to_back();
      test_reset_mid();
      test_frame(8'h12, 8'h45, 8'h23);
      for (int k = 0; k < 3; k++) begin
         test_frame(8'($urandom), 8'($urandom), 8'($urandom));
      end
      test_frame(8'hFF, 8'hFF, 8'hFF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
